// File: rtl/local_bus_arbiter.sv
// rtl/local_bus_arbiter.sv - 68040 local bus arbiter for CPU, PCI bridge and DMA masters
//
// Purpose : grants the local bus to one of three masters. The CPU is the
//           parking master. Every change of owner goes through REVOKE, which
//           waits for the bus to go idle, and then DEAD, which holds the bus
//           with no grant for TURNAROUND clocks before the next owner is chosen.
// Ports   : i_bclk                 bus clock, rising edge
//           i_nreset               asynchronous active-low reset
//           i_nbr_cpu/pci/dma      bus requests, active low
//           i_nbb                  bus busy, active low
//           i_nts / i_nta          transfer start / transfer acknowledge, active low
//           o_nbg_cpu/pci/dma      registered bus grants, active low, at most one low
//           o_owner                00 CPU, 01 PCI, 10 DMA, 11 none
//           o_bus_idle             registered (nBB high and no transfer outstanding)
// Config  : define ARB_TENURE_LIMIT_EN to let a contested PCI/DMA tenure be
//           cut off after TENURE_MAX busy clocks.
module local_bus_arbiter #(
   parameter int unsigned TENURE_MAX = 64,
   parameter int unsigned TURNAROUND = 1
) (
   input  logic       i_bclk,
   input  logic       i_nreset,
   input  logic       i_nbr_cpu,
   input  logic       i_nbr_pci,
   input  logic       i_nbr_dma,
   input  logic       i_nbb,
   input  logic       i_nts,
   input  logic       i_nta,
   output logic       o_nbg_cpu,
   output logic       o_nbg_pci,
   output logic       o_nbg_dma,
   output logic [1:0] o_owner,
   output logic       o_bus_idle
);

   localparam logic [1:0] OWN_CPU  = 2'b00;
   localparam logic [1:0] OWN_PCI  = 2'b01;
   localparam logic [1:0] OWN_DMA  = 2'b10;
   localparam logic [1:0] OWN_NONE = 2'b11;
   localparam logic [1:0] LP_DEAD_LAST = 2'(TURNAROUND - 1);
   localparam logic [7:0] LP_TENURE    = 8'(TENURE_MAX);

   typedef enum logic [2:0] {
      ST_GRANT_CPU = 3'd0,
      ST_GRANT_PCI = 3'd1,
      ST_GRANT_DMA = 3'd2,
      ST_REVOKE    = 3'd3,
      ST_DEAD      = 3'd4
   } state_t;

   state_t     r_state;
   state_t     w_next_state;
   state_t     w_winner;
   logic       r_req_pci;
   logic       r_req_dma;
   logic       r_flag;
   logic       r_bus_idle;
   logic [1:0] r_dead_cnt;
   logic       w_dma_ok;
   logic       w_pci_ok;
   logic       w_tenure_hit;
   logic       w_nbg_cpu;
   logic       w_nbg_pci;
   logic       w_nbg_dma;
   logic [1:0] w_owner;

   // Requests are registered once, so arbitration decisions always act on a
   // request one clock after it was sampled.
   always_ff @(posedge i_bclk or negedge i_nreset) begin
      if (!i_nreset) begin
         r_req_pci  <= 1'b0;
         r_req_dma  <= 1'b0;
         r_flag     <= 1'b0;
         r_bus_idle <= 1'b0;
         r_dead_cnt <= 2'd0;
      end else begin
         r_req_pci  <= ~i_nbr_pci;
         r_req_dma  <= ~i_nbr_dma;
         // A start seen together with an acknowledge belongs to a new transfer.
         r_flag     <= ~i_nts | (r_flag & i_nta);
         r_bus_idle <= i_nbb & ~r_flag;
         r_dead_cnt <= (r_state == ST_DEAD) ? r_dead_cnt + 2'd1 : 2'd0;
      end
   end

`ifdef ARB_TENURE_LIMIT_EN
   logic       r_req_cpu;
   logic [7:0] r_tenure;
   logic [1:0] r_demote;   // master cut off by the tenure limit, ranked last once

   always_ff @(posedge i_bclk or negedge i_nreset) begin
      if (!i_nreset) begin
         r_req_cpu <= 1'b0;
         r_tenure  <= 8'd0;
         r_demote  <= OWN_NONE;
      end else begin
         r_req_cpu <= ~i_nbr_cpu;
         if ((w_next_state != r_state) &&
             (w_next_state == ST_GRANT_PCI || w_next_state == ST_GRANT_DMA))
            r_tenure <= 8'd0;
         else if (!i_nbb && r_tenure != 8'hFF)
            r_tenure <= r_tenure + 8'd1;
         if ((r_state == ST_GRANT_PCI || r_state == ST_GRANT_DMA) &&
             w_next_state == ST_REVOKE && w_tenure_hit)
            r_demote <= (r_state == ST_GRANT_PCI) ? OWN_PCI : OWN_DMA;
         else if (r_state == ST_DEAD && r_dead_cnt == LP_DEAD_LAST)
            r_demote <= OWN_NONE;
      end
   end

   assign w_tenure_hit = (r_tenure >= LP_TENURE) &&
                         (((r_state == ST_GRANT_PCI) && (r_req_dma || r_req_cpu)) ||
                          ((r_state == ST_GRANT_DMA) && (r_req_pci || r_req_cpu)));
   assign w_dma_ok = r_req_dma && !(r_demote == OWN_DMA && (r_req_pci || r_req_cpu));
   assign w_pci_ok = r_req_pci && !(r_demote == OWN_PCI && (r_req_dma || r_req_cpu));
`else
   // The CPU request never changes the outcome when it only parks the bus.
   logic w_unused;
   assign w_unused     = ^{i_nbr_cpu, LP_TENURE};
   assign w_tenure_hit = 1'b0;
   assign w_dma_ok     = r_req_dma;
   assign w_pci_ok     = r_req_pci;
`endif

   assign w_winner = w_dma_ok ? ST_GRANT_DMA : (w_pci_ok ? ST_GRANT_PCI : ST_GRANT_CPU);

   always_ff @(posedge i_bclk or negedge i_nreset) begin
      if (!i_nreset)
         r_state <= ST_GRANT_CPU;
      else
         r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_GRANT_CPU: if (r_req_pci || r_req_dma) w_next_state = ST_REVOKE;
         ST_GRANT_PCI: if (r_req_dma || (!r_req_pci && r_bus_idle) || w_tenure_hit)
                          w_next_state = ST_REVOKE;
         ST_GRANT_DMA: if ((!r_req_dma && r_bus_idle) || w_tenure_hit)
                          w_next_state = ST_REVOKE;
         ST_REVOKE:    if (r_bus_idle) w_next_state = ST_DEAD;
         ST_DEAD:      if (r_dead_cnt == LP_DEAD_LAST) w_next_state = w_winner;
         default:      w_next_state = ST_GRANT_CPU;
      endcase
   end

   // Outputs are decoded from the next state and registered, so grants move
   // on the same edge as the state.
   always_comb begin
      w_nbg_cpu = 1'b1;
      w_nbg_pci = 1'b1;
      w_nbg_dma = 1'b1;
      w_owner   = OWN_NONE;
      case (w_next_state)
         ST_GRANT_CPU: begin w_nbg_cpu = 1'b0; w_owner = OWN_CPU; end
         ST_GRANT_PCI: begin w_nbg_pci = 1'b0; w_owner = OWN_PCI; end
         ST_GRANT_DMA: begin w_nbg_dma = 1'b0; w_owner = OWN_DMA; end
         default:      w_owner = OWN_NONE;
      endcase
   end

   always_ff @(posedge i_bclk or negedge i_nreset) begin
      if (!i_nreset) begin
         o_nbg_cpu <= 1'b0;
         o_nbg_pci <= 1'b1;
         o_nbg_dma <= 1'b1;
         o_owner   <= OWN_CPU;
      end else begin
         o_nbg_cpu <= w_nbg_cpu;
         o_nbg_pci <= w_nbg_pci;
         o_nbg_dma <= w_nbg_dma;
         o_owner   <= w_owner;
      end
   end

   assign o_bus_idle = r_bus_idle;

endmodule
